scan_chain_ctrl: RTL and testbench

//  Drives one mux-scan flop chain and checks its response. Loads a test pattern

---
 rtl/scan_chain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into one mux-scan chain, pulses one capture
// cycle, unloads the chain and compares the result against a masked expected vector.
//   clk, rst              : single clock (it also clocks the chain); synchronous active-high reset
//   start                 : request, accepted only in IDLE
//   pat_in/exp_in/mask_in : pattern, expected capture value and compare mask, latched on accept
//   scan_out              : Q of the last chain cell
//   scan_en/scan_in       : chain SEL and TD of cell 0
//   busy/done/pass        : sequence status
//   cap_data/fail_mask    : unloaded contents and the masked miscompare bits
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] cap_data,
  output logic [CHAIN_LEN-1:0] fail_mask
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] fail_q, fail_d;
  logic [CHAIN_LEN-1:0] cap_shift;
  logic [CHAIN_LEN-1:0] miscmp;

  // pat_q is kept as a left-shifting copy of the pattern so its MSB is always the
  // next TD bit; cap_q shifts left so the first unloaded bit (cell N-1) lands at the MSB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    scan_en_d = scan_en_q;
    scan_in_d = scan_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    cap_d     = cap_q;
    fail_d    = fail_q;
    cap_shift = {cap_q[CHAIN_LEN-2:0], scan_out};
    miscmp    = (cap_shift ^ exp_q) & mask_q;

    unique case (state_q)
      IDLE: begin
        scan_en_d = 1'b0;
        if (start) begin
          state_d   = SHIFT_IN;
          cnt_d     = '0;
          busy_d    = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = pat_in[CHAIN_LEN-1];
          pat_d     = {pat_in[CHAIN_LEN-2:0], 1'b0};
          exp_d     = exp_in;
          mask_d    = mask_in;
          pass_d    = 1'b0;
          cap_d     = '0;
          fail_d    = '0;
        end
      end
      SHIFT_IN: begin
        pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == LAST) begin
          state_d   = CAPTURE;
          cnt_d     = '0;
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          scan_in_d = pat_q[CHAIN_LEN-1];
        end
      end
      CAPTURE: begin
        state_d   = SHIFT_OUT;
        cnt_d     = '0;
        scan_en_d = 1'b1;
        scan_in_d = 1'b0;
      end
      SHIFT_OUT: begin
        cap_d = cap_shift;
        if (cnt_q == LAST) begin
          state_d   = DONE;
          cnt_d     = '0;
          scan_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          fail_d    = miscmp;
          pass_d    = ~|miscmp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        cnt_d     = '0;
        scan_en_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        scan_en_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cap_q     <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      mask_q    <= mask_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cap_q     <= cap_d;
      fail_q    <= fail_d;
    end
  end

  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cap_data  = cap_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;

  localparam int N = 8;
  localparam int LAT = 2 * N + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] pat_in = '0;
  logic [N-1:0] exp_in = '0;
  logic [N-1:0] mask_in = '0;
  logic         scan_out;
  logic         scan_en;
  logic         scan_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] cap_data;
  logic [N-1:0] fail_mask;

  // external chain model: functional D bus and an optional capture bypass
  logic [N-1:0] chain = '0;
  logic [N-1:0] d_fn = '0;
  bit           bypass = 1'b0;

  int errors = 0;
  int checks = 0;
  int ph = 0;          // 0 = idle, otherwise cycles since the accepted start
  int done_cnt = 0;
  int exp_dones = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pat_in    (pat_in),
    .exp_in    (exp_in),
    .mask_in   (mask_in),
    .scan_out  (scan_out),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .cap_data  (cap_data),
    .fail_mask (fail_mask)
  );

  assign scan_out = chain[N-1];

  always @(posedge clk) begin
    if (scan_en) chain <= {chain[N-2:0], scan_in};
    else if (!bypass) chain <= d_fn;
  end

  always @(posedge clk) begin
    if (rst) ph <= 0;
    else if (ph == 0) begin
      if (start) ph <= 1;
    end else if (ph == LAT) ph <= 0;
    else ph <= ph + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_scan_en", 32'(scan_en), 32'((ph >= 1 && ph <= N) || (ph >= N + 2 && ph <= 2 * N + 1)));
      check("mon_busy", 32'(busy), 32'(ph >= 1 && ph <= 2 * N + 1));
      check("mon_done", 32'(done), 32'(ph == LAT));
      check("mon_busy_and_done", 32'(busy & done), 32'(0));
      if (ph >= N + 1 && ph <= 2 * N + 1) check("mon_scan_in_zero", 32'(scan_in), 32'(0));
      if (done === 1'b1) done_cnt++;
    end
  end

  // called on the first negedge after the accept edge; lat = cycles until done seen
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 1;
    while (!seen && lat <= 3 * LAT) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic run(input string tag, input logic [N-1:0] dfn, input logic [N-1:0] pt,
                     input logic [N-1:0] ex, input logic [N-1:0] mk, input bit byp);
    logic [N-1:0] cap_e;
    logic [N-1:0] fail_e;
    int lat;
    cap_e  = byp ? pt : dfn;
    fail_e = (cap_e ^ ex) & mk;
    d_fn = dfn; bypass = byp;
    pat_in = pt; exp_in = ex; mask_in = mk;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pat_in = N'($urandom); exp_in = N'($urandom); mask_in = N'($urandom);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_cap"}, 32'(cap_data), 32'(cap_e));
    check({tag, "_fail"}, 32'(fail_mask), 32'(fail_e));
    check({tag, "_pass"}, 32'(pass), 32'(fail_e == '0));
    exp_dones++;
    @(negedge clk);
    check({tag, "_pass_hold"}, 32'(pass), 32'(fail_e == '0));
    check({tag, "_cap_hold"}, 32'(cap_data), 32'(cap_e));
  endtask

  initial begin
    int lat;
    logic [N-1:0] a, b, c, m;
    bit bp;

    repeat (3) @(negedge clk);
    check("rst_scan_en", 32'(scan_en), 32'(0));
    check("rst_scan_in", 32'(scan_in), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_cap", 32'(cap_data), 32'(0));
    check("rst_fail", 32'(fail_mask), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run("t1", 8'hA5, 8'h3C, 8'hA5, 8'hFF, 1'b0);
    run("t2a", 8'hA5, 8'h3C, 8'hA4, 8'hFF, 1'b0);
    run("t2b", 8'hA5, 8'h3C, 8'hA4, 8'hFE, 1'b0);
    run("t3_bypass", 8'hA5, 8'h3C, 8'hA5, 8'hFF, 1'b1);
    run("mask0", 8'h5A, 8'hC3, 8'h0F, 8'h00, 1'b0);

    // start pulses at cycle 5 and 18 are ignored; the one at cycle 19 is taken
    d_fn = 8'hA5; bypass = 1'b0; pat_in = 8'h3C; exp_in = 8'hA5; mask_in = 8'hFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_done_at_18", 32'(done), 32'(1));
    check("t4_cap", 32'(cap_data), 32'(8'hA5));
    exp_dones++;
    start = 1'b1;
    @(negedge clk);
    check("t4_start18_ignored", 32'(busy), 32'(0));
    @(negedge clk); start = 1'b0;
    check("t4_start19_taken", 32'(busy), 32'(1));
    wait_done(lat);
    check("t4_second_latency", 32'(lat), 32'(LAT));
    check("t4_second_pass", 32'(pass), 32'(1));
    exp_dones++;
    @(negedge clk);
    check("t4_done_count", 32'(done_cnt), 32'(exp_dones));

    // reset in the middle of the unload abandons the run
    run("t5_pre", 8'h81, 8'h00, 8'h81, 8'hFF, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t5_scan_en", 32'(scan_en), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_done", 32'(done), 32'(0));
    check("t5_pass", 32'(pass), 32'(0));
    check("t5_cap", 32'(cap_data), 32'(0));
    check("t5_fail", 32'(fail_mask), 32'(0));
    repeat (2 * LAT) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'(exp_dones));
    run("t5_restart", 8'h66, 8'h99, 8'h66, 8'hF0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      a  = N'($urandom);
      b  = N'($urandom);
      bp = 1'($urandom_range(0, 1));
      m  = N'($urandom);
      c  = ($urandom_range(0, 1) == 1) ? (bp ? b : a) : N'($urandom);
      run("rand", a, b, c, m, bp);
    end

    check("final_done_count", 32'(done_cnt), 32'(exp_dones));
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
